// File: rtl/conv_window_ctrl.sv
// ============================================================================
// Module   : conv_window_ctrl
// Purpose  : 3x3 convolution window sequencer over an IMG_W x IMG_H image with
//            a runtime stride. Optional macro CONV_CTRL_PERF_EN adds a stall counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_window_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  stride,
  input  logic        conv_ready,
  output logic        window_en,
  output logic        shift_buffer,
  output logic        conv_valid,
  output logic        row_adv,
  output logic        busy,
  output logic        done,
  output logic [7:0]  col_idx,
  output logic [7:0]  row_idx,
  output logic [15:0] perf_stall
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRELOAD  = 3'd1,
    LOAD     = 3'd2,
    CONVOLVE = 3'd3,
    ROW_END  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [9:0] C_IMG_W = 10'(IMG_W);
  localparam logic [9:0] C_IMG_H = 10'(IMG_H);

  state_t     state_q, state_d;
  logic [1:0] stride_q, stride_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] col_q, col_d;
  logic [7:0] row_q, row_d;

  logic       col_fits, row_fits;
  logic       we;

  // Widened so IMG up to 255 plus stride and window size cannot wrap.
  assign col_fits = ({2'b00, col_q} + {8'd0, stride_q} + 10'd3) <= C_IMG_W;
  assign row_fits = ({2'b00, row_q} + {8'd0, stride_q} + 10'd3) <= C_IMG_H;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      stride_q <= 2'd1;
      cnt_q    <= 2'd0;
      col_q    <= 8'd0;
      row_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    we         = 1'b0;
    conv_valid = 1'b0;
    row_adv    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stride_d = (stride == 2'd0) ? 2'd1 : stride;
          col_d    = 8'd0;
          row_d    = 8'd0;
          cnt_d    = 2'd0;
          state_d  = PRELOAD;
        end
      end
      PRELOAD: begin
        we = 1'b1;
        if (cnt_q == 2'd2) begin
          cnt_d   = 2'd0;
          state_d = CONVOLVE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      LOAD: begin
        we = 1'b1;
        if (cnt_q == stride_q - 2'd1) begin
          cnt_d   = 2'd0;
          state_d = CONVOLVE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      CONVOLVE: begin
        conv_valid = 1'b1;
        if (conv_ready) begin
          if (col_fits) begin
            col_d   = col_q + {6'd0, stride_q};
            cnt_d   = 2'd0;
            state_d = LOAD;
          end else begin
            state_d = ROW_END;
          end
        end
      end
      ROW_END: begin
        if (row_fits) begin
          row_adv = 1'b1;
          row_d   = row_q + {6'd0, stride_q};
          col_d   = 8'd0;
          cnt_d   = 2'd0;
          state_d = PRELOAD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign window_en    = we;
  assign shift_buffer = we;
  assign busy         = (state_q != IDLE);
  assign col_idx      = col_q;
  assign row_idx      = row_q;

`ifdef CONV_CTRL_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= 16'd0;
    end else if ((state_q == CONVOLVE) && !conv_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall = stall_q;
`else
  assign perf_stall = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
// ============================================================================
// Module   : tb_conv_window_ctrl
// Purpose  : Scoreboard bench for conv_window_ctrl on an 8x8 image.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_window_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  stride;
  logic        conv_ready;
  logic        window_en, shift_buffer, conv_valid, row_adv, busy, done;
  logic [7:0]  col_idx, row_idx;
  logic [15:0] perf_stall;

  conv_window_ctrl #(.IMG_W(8), .IMG_H(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stride(stride), .conv_ready(conv_ready),
    .window_en(window_en), .shift_buffer(shift_buffer), .conv_valid(conv_valid),
    .row_adv(row_adv), .busy(busy), .done(done), .col_idx(col_idx),
    .row_idx(row_idx), .perf_stall(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];
  int xfer_cnt, rowadv_cnt, done_cnt, we_cnt, gap_cnt, gap_err, inv_err, exp_gap;

`ifdef CONV_CTRL_PERF_EN
  localparam int EXP_STALL = 5;
`else
  localparam int EXP_STALL = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops one expected {col,row} for every accepted window.
  always @(negedge clk) begin
    if (!rst) begin
      if (window_en !== shift_buffer) inv_err++;
      if (conv_valid && window_en) inv_err++;
      if (window_en) begin
        gap_cnt++;
        we_cnt++;
      end
      if (row_adv) rowadv_cnt++;
      if (done) done_cnt++;
      if (conv_valid && conv_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("xfer_unexpected", 32'd1, 32'd0);
        else check("xfer_col_row", {16'd0, col_idx, row_idx}, {16'd0, exp_q.pop_front()});
        if (col_idx != 8'd0 && gap_cnt != exp_gap) gap_err++;
        gap_cnt = 0;
      end
    end
  end

  task automatic start_pass(input logic [1:0] s, input int eff,
                            input logic [7:0] cols[$], input logic [7:0] rows[$]);
    foreach (rows[r]) foreach (cols[c]) exp_q.push_back({cols[c], rows[r]});
    xfer_cnt = 0; rowadv_cnt = 0; done_cnt = 0; we_cnt = 0;
    gap_cnt = 0; gap_err = 0; inv_err = 0; exp_gap = eff;
    @(posedge clk); #1 stride = s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_pass(input string tag, input int exp_x, input int exp_ra, input bit inject);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      start = inject && (i == 20);
      if (inject && i == 20) stride = 2'd2;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_xfers"}, xfer_cnt, exp_x);
    check({tag, "_row_adv"}, rowadv_cnt, exp_ra);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    check({tag, "_invariants"}, inv_err, 32'd0);
    check({tag, "_load_gap"}, gap_err, 32'd0);
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] c1[$], r1[$], c2[$], c3[$];
    bit hit;
    c1 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    r1 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    c2 = '{8'd0, 8'd2, 8'd4};
    c3 = '{8'd0, 8'd3};
    rst = 1'b0; start = 1'b0; stride = 2'd0; conv_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_1bit_outs", {26'd0, window_en, shift_buffer, conv_valid, row_adv, busy, done}, 32'd0);
    check("reset_idx", {16'd0, col_idx, row_idx}, 32'd0);
    check("reset_perf", {16'd0, perf_stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Stall on the first window, then a full stride-1 pass.
    start_pass(2'd1, 1, c1, r1);
    repeat (2) @(posedge clk);
    #1 check("valid_not_before_4th", {31'd0, conv_valid}, 32'd0);
    @(posedge clk);
    #1 check("valid_in_4th_cycle", {31'd0, conv_valid}, 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
      check("stall_hold", {30'd0, conv_valid, window_en}, 32'd2);
    end
    @(posedge clk);
    #1 check("perf_stall", {16'd0, perf_stall}, EXP_STALL);
    conv_ready = 1'b1;
    finish_pass("s1", 36, 5, 1'b0);

    start_pass(2'd2, 2, c2, c2);
    finish_pass("s2", 9, 2, 1'b0);
    start_pass(2'd3, 3, c3, c3);
    finish_pass("s3", 4, 1, 1'b0);
    start_pass(2'd0, 1, c1, r1);
    finish_pass("s0", 36, 5, 1'b0);

    // Asynchronous reset in a LOAD cycle on row 2.
    start_pass(2'd1, 1, c1, r1);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (row_idx == 8'd2 && window_en && col_idx != 8'd0) hit = 1'b1;
    end
    check("reached_load_row2", {31'd0, hit}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midpass_rst_1bit", {26'd0, window_en, shift_buffer, conv_valid, row_adv, busy, done}, 32'd0);
    check("midpass_rst_idx", {16'd0, col_idx, row_idx}, 32'd0);
    check("midpass_rst_perf", {16'd0, perf_stall}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    we_cnt = 0; xfer_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    check("idle_after_rst", {30'd0, busy, conv_valid}, 32'd0);
    check("no_activity_after_rst", we_cnt + xfer_cnt, 32'd0);

    // Fresh pass; a start/stride change while busy must be ignored.
    start_pass(2'd1, 1, c1, r1);
    finish_pass("fresh", 36, 5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 8, meaning image width in pixels (3..255).
REQ-002 The block SHALL have parameter IMG_H, default 8, meaning image height in rows (3..255).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, meaning begin one image pass; sampled only in IDLE.
REQ-006 The block SHALL have port stride, input, 2, meaning window step 1..3; value 0 treated as 1; latched at start.
REQ-007 The block SHALL have port conv_ready, input, 1, meaning the downstream MAC accepts the current window.
REQ-008 The block SHALL have port window_en, output, 1, meaning shift one new column into the 3x3 window.
REQ-009 The block SHALL have port shift_buffer, output, 1, meaning pop one pixel from each of the three line buffers.
REQ-010 The block SHALL have port conv_valid, output, 1, meaning the window holds a complete 3x3 patch.
REQ-011 The block SHALL have port row_adv, output, 1, meaning a one-cycle pulse telling the line buffers to advance by the latched stride rows.
REQ-012 The block SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1, meaning a one-cycle pulse at the end of a pass.
REQ-014 The block SHALL have ports col_idx and row_idx, output, 8 each, meaning the left column and top row of the current window.
REQ-015 The block SHALL have port perf_stall, output, 16, meaning the stall counter (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE, PRELOAD, LOAD, CONVOLVE, ROW_END and DONE.
REQ-017 IDLE with start=1 SHALL latch stride, clear col_idx and row_idx, and move to PRELOAD.
REQ-018 PRELOAD SHALL assert window_en and shift_buffer for exactly 3 consecutive cycles, then enter CONVOLVE.
REQ-019 CONVOLVE SHALL hold conv_valid=1, with window_en=0 and shift_buffer=0, until conv_ready=1; the transfer completes on the cycle where conv_valid and conv_ready are both 1.
REQ-020 After a transfer, if col_idx+stride+3 <= IMG_W, the FSM SHALL enter LOAD, add stride to col_idx, and assert window_en and shift_buffer for exactly stride cycles before returning to CONVOLVE.
REQ-021 Otherwise, after a transfer, the FSM SHALL enter ROW_END.
REQ-022 ROW_END SHALL last 1 cycle; if row_idx+stride+3 <= IMG_H it SHALL pulse row_adv, add stride to row_idx, clear col_idx and go to PRELOAD; else it SHALL go to DONE.
REQ-023 DONE SHALL pulse done for 1 cycle, then return to IDLE.
REQ-024 The first conv_valid SHALL appear 4 cycles after the start-sampling edge.
REQ-025 Windows per row SHALL be floor((IMG_W-3)/stride)+1; rows SHALL be floor((IMG_H-3)/stride)+1.
REQ-026 start while busy=1 SHALL be ignored, and a stride change mid-pass SHALL have no effect.
REQ-027 window_en and shift_buffer SHALL always be equal, and both SHALL be 0 whenever conv_valid=1.

Reset
REQ-028 rst=1 SHALL force, at any time including mid-pass, state IDLE, all 1-bit outputs 0, col_idx=0, row_idx=0, perf_stall=0 and latched stride=1.
REQ-029 After rst deasserts, the block SHALL require a new start before any activity.

Configuration
REQ-030 With macro CONV_CTRL_PERF_EN defined, perf_stall SHALL count cycles with conv_valid=1 and conv_ready=0, saturate at 16'hFFFF, and clear on each accepted start.
REQ-031 With CONV_CTRL_PERF_EN undefined, perf_stall SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-032 The bench SHALL cover: IMG_W=8, IMG_H=8, stride=1, conv_ready=1 -> 36 conv_valid transfers, 5 row_adv pulses, 1 done pulse.
REQ-033 The bench SHALL cover: stride=2 -> 9 transfers; col_idx sequence 0,2,4 on each row; row_idx 0,2,4; 2 row_adv pulses.
REQ-034 The bench SHALL cover: stride=3 -> 4 transfers; exactly 3 window_en cycles between consecutive windows in the same row; stride=0 -> behaves as stride=1, giving 36 transfers.
REQ-035 The bench SHALL cover: conv_ready held 0 for 5 cycles on the first window -> conv_valid held with no window_en; perf_stall=5 with CONV_CTRL_PERF_EN defined, 0 without it.
REQ-036 The bench SHALL cover: rst asserted during LOAD of row 2 -> all outputs 0 the same cycle; start asserted while busy -> ignored; a fresh start -> a full 36-transfer pass.
